// File: rtl/mod_sub_serial.sv
// mod_sub_serial: nibble-serial modular subtractor, result = (a - b) mod m.
// Pass 1 adds a + ~b + 1 one nibble per cycle; on borrow, pass 2 adds m back.
// Ports: clk, rst (async, active-high), start/a/b/m (request, sampled on
// accept), busy (not idle), done (1-cycle pulse), wrapped (add-back ran),
// result (held until the next operation completes).
module mod_sub_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic [WIDTH-1:0] result
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [3:0]         x, y, p, g, c, sum4;
  logic               cout;
  logic [WIDTH+3:0]   acc_cat;
  logic [WIDTH-1:0]   acc_nx;
  logic [2*WIDTH-1:0] rot_a_cat, rot_b_cat;
  logic [WIDTH-1:0]   rot_a, rot_b;
  logic               last;

  // 4-bit carry-lookahead adder on the current low nibbles
  always_comb begin
    x = op_a[3:0];
    y = op_b[3:0];
    p = x ^ y;
    g = x & y;
    c[0] = carry;
    c[1] = g[0] | (p[0] & carry);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    sum4 = p ^ c;
  end

  // Concatenate-then-shift forms stay legal when WIDTH == 4
  always_comb begin
    acc_cat   = {sum4, acc};
    acc_nx    = acc_cat[WIDTH+3:4];
    rot_a_cat = {op_a, op_a} >> 4;
    rot_b_cat = {op_b, op_b} >> 4;
    rot_a     = rot_a_cat[WIDTH-1:0];
    rot_b     = rot_b_cat[WIDTH-1:0];
    last      = (idx == IW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrapped <= 1'b0;
      result  <= '0;
      op_a    <= '0;
      op_b    <= '0;
      m_r     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      idx     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= ~b;
            m_r   <= m;
            carry <= 1'b1;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SUB;
          end
        end
        SUB, FIX: begin
          op_a  <= rot_a;
          op_b  <= rot_b;
          acc   <= acc_nx;
          carry <= cout;
          idx   <= idx + 1'b1;
          if (last) begin
            if (state == SUB && !cout) begin
              // borrow: add the modulus back to the difference
              op_a  <= acc_nx;
              op_b  <= m_r;
              carry <= 1'b0;
              idx   <= '0;
              state <= FIX;
            end else begin
              result  <= acc_nx;
              wrapped <= (state == FIX);
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_sub_serial.sv
// tb_mod_sub_serial: self-checking bench for mod_sub_serial.
// Drives a 16-bit and a 4-bit instance; compares to an arithmetic model.
module tb_mod_sub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s16, busy16, done16, wr16;
  logic [15:0] a16, b16, m16, r16;
  logic        s4, busy4, done4, wr4;
  logic [3:0]  a4, b4, m4, r4;

  mod_sub_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .m(m16),
    .busy(busy16), .done(done16), .wrapped(wr16), .result(r16)
  );

  mod_sub_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .m(m4),
    .busy(busy4), .done(done4), .wrapped(wr4), .result(r4)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [15:0] a, b, m, res;
    logic        wr;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // (a - b) mod m as the two-pass rule defines it, mod 2^w
  task automatic model(input int w, input int ia, input int ib,
                       input int im, output int res, output logic wr,
                       output int lat);
    int mask, n;
    mask = (1 << w) - 1;
    n = w / 4;
    if (ia >= ib) begin
      res = ia - ib;
      wr  = 1'b0;
      lat = n + 1;
    end else begin
      res = (ia - ib + im) & mask;
      wr  = 1'b1;
      lat = 2 * n + 1;
    end
  endtask

  task automatic run16(input logic [15:0] ia, ib, im,
                       output logic [15:0] res, output logic wr,
                       output int lat);
    @(negedge clk);
    a16 = ia; b16 = ib; m16 = im; s16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 100) begin
      chk("busy16_run", busy16, 1);
      @(negedge clk);
      lat++;
    end
    chk("done16_seen", done16, 1);
    chk("busy16_done", busy16, 1);
    res = r16;
    wr = wr16;
    @(negedge clk);
    chk("done16_pulse", done16, 0);
    chk("busy16_idle", busy16, 0);
  endtask

  task automatic run4(input logic [3:0] ia, ib, im,
                      output logic [3:0] res, output logic wr,
                      output int lat);
    @(negedge clk);
    a4 = ia; b4 = ib; m4 = im; s4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("done4_seen", done4, 1);
    res = r4;
    wr = wr4;
    @(negedge clk);
    chk("busy4_idle", busy4, 0);
  endtask

  vec_t vt[6];

  initial begin
    logic [15:0] res, ea, eb, em;
    logic [3:0]  res4;
    logic        wr, ewr;
    int          lat, eres, elat, cyc, d1, d2;
    bit          seen_done;

    vt[0] = '{"small_nb",  16'h0005, 16'h0003, 16'h000B, 16'h0002, 1'b0, 5};
    vt[1] = '{"small_b",   16'h0003, 16'h0005, 16'h000B, 16'h0009, 1'b1, 9};
    vt[2] = '{"equal",     16'h1234, 16'h1234, 16'hFFF1, 16'h0000, 1'b0, 5};
    vt[3] = '{"ripple",    16'h0000, 16'hFFF0, 16'hFFF1, 16'h0001, 1'b1, 9};
    vt[4] = '{"big_nb",    16'hFFF0, 16'h0000, 16'hFFF1, 16'hFFF0, 1'b0, 5};
    vt[5] = '{"minus_one", 16'h8000, 16'h8001, 16'hFFFF, 16'hFFFE, 1'b1, 9};

    rst = 1'b1;
    s16 = 1'b0; a16 = '0; b16 = '0; m16 = '0;
    s4 = 1'b0; a4 = '0; b4 = '0; m4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_wrapped", wr16, 0);
    chk("rst_result", r16, 0);
    chk("rst_busy4", busy4, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run16(vt[i].a, vt[i].b, vt[i].m, res, wr, lat);
      chk({vt[i].nm, "_res"}, res, vt[i].res);
      chk({vt[i].nm, "_wr"}, wr, vt[i].wr);
      chk({vt[i].nm, "_lat"}, lat, vt[i].lat);
    end

    // start while busy is ignored
    @(negedge clk);
    a16 = 16'h0005; b16 = 16'h0003; m16 = 16'h000B; s16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s16 = 1'b0;
    lat = 1;
    @(negedge clk); lat++;
    @(negedge clk); lat++;
    a16 = 16'h0007; b16 = 16'h0001; m16 = 16'h000B; s16 = 1'b1;
    @(negedge clk); lat++;
    s16 = 1'b0;
    while (!done16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", lat, 5);
    chk("ign_res", r16, 16'h0002);
    @(negedge clk);
    chk("ign_noqueue", busy16, 0);
    @(negedge clk);
    chk("ign_noqueue2", busy16, 0);

    // start held high: back-to-back, 6 cycles apart
    a16 = 16'h0005; b16 = 16'h0003; m16 = 16'h000B; s16 = 1'b1;
    d1 = -1; d2 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done16) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    s16 = 1'b0;
    chk("b2b_first", d1, 5);
    chk("b2b_gap", d2 - d1, 6);
    chk("b2b_res", r16, 16'h0002);
    cyc = 0;
    while (busy16 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_drain", busy16, 0);

    // wrapped op so reset has nonzero outputs to clear
    run16(16'h0003, 16'h0005, 16'h000B, res, wr, lat);
    chk("pre_rst_wr", wr, 1);

    // async reset mid-FIX
    @(negedge clk);
    a16 = 16'h0003; b16 = 16'h0005; m16 = 16'h000B; s16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s16 = 1'b0;
    lat = 1;
    while (lat < 7) begin
      @(negedge clk);
      lat++;
    end
    chk("fix_busy", busy16, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy16, 0);
    chk("arst_done", done16, 0);
    chk("arst_wr", wr16, 0);
    chk("arst_res", r16, 0);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done16 || busy16) seen_done = 1'b1;
    end
    chk("arst_no_done", seen_done, 0);
    run16(16'h0005, 16'h0003, 16'h000B, res, wr, lat);
    chk("post_rst_res", res, 16'h0002);
    chk("post_rst_lat", lat, 5);

    // operands change right after accept
    @(negedge clk);
    a16 = 16'h0100; b16 = 16'h0200; m16 = 16'h0FFF; s16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); m16 = 16'($urandom);
    lat = 1;
    while (!done16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latch_res", r16, 16'h0EFF);
    chk("latch_wr", wr16, 1);
    chk("latch_lat", lat, 9);
    @(negedge clk);

    // random 16-bit, mostly within preconditions
    for (int i = 0; i < 200; i++) begin
      if (i < 150) begin
        em = 16'($urandom_range(1, 65535));
        ea = 16'($urandom % em);
        eb = 16'($urandom % em);
      end else begin
        em = 16'($urandom);
        ea = 16'($urandom);
        eb = 16'($urandom);
      end
      model(16, int'(ea), int'(eb), int'(em), eres, ewr, elat);
      run16(ea, eb, em, res, wr, lat);
      chk("rnd_res", res, eres);
      chk("rnd_wr", wr, ewr);
      chk("rnd_lat", lat, elat);
    end

    // exhaustive WIDTH=4 sweep
    for (int mm = 1; mm < 16; mm++) begin
      for (int aa = 0; aa < mm; aa++) begin
        for (int bb = 0; bb < mm; bb++) begin
          model(4, aa, bb, mm, eres, ewr, elat);
          run4(4'(aa), 4'(bb), 4'(mm), res4, wr, lat);
          chk("w4_res", res4, eres);
          chk("w4_wr", wr, ewr);
          chk("w4_lat", lat, elat);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod_sub_serial.md
Name: mod_sub_serial

Overview:
- Nibble-serial modular subtractor for the modular-division datapath: computes r = (a - b) mod m for a, b already reduced (a < m, b < m).
- One 4-bit carry-lookahead nibble adder per cycle. Pass 1 adds a + ~b + 1. If pass 1 borrows, pass 2 adds m back.
- Start/busy/done handshake toward the division controller.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 nibble steps per pass.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  minuend, sampled on accept
- b  input  WIDTH  subtrahend, sampled on accept
- m  input  WIDTH  modulus, sampled on accept
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result valid
- wrapped  output  1  high when the modulus add-back pass ran for the last operation
- result  output  WIDTH  (a - b) mod m

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; wrapped=0; result=0; internal operand/shift registers and carry cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, SUB, FIX, DONE.
- IDLE, start=1 at edge T: latch a, b, m; opA=a, opB=~b, carry=1, idx=0; go to SUB. start=0 stays in IDLE.
- SUB, cycles T+1..T+N:
  - Nibble adder takes opA[3:0], opB[3:0] and carry, producing sum4 and cout.
  - opA and opB rotate right by 4. sum4 shifts into the top nibble of the accumulator (LSB nibble first). carry<=cout; idx++.
  - Last nibble (idx==N-1), final cout=1 (no borrow): result<=difference, wrapped<=0, go to DONE.
  - Last nibble, final cout=0 (borrow, a<b): reload opA=difference, opB=m, carry=0, idx=0, go to FIX.
- FIX, N cycles: same nibble stepping. After the last nibble: result<=sum mod 2^WIDTH (final carry discarded), wrapped<=1, go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- Latency from the accepting edge T:
  - no borrow: done high in cycle T+N+1
  - borrow: done high in cycle T+2N+1
- busy is high from T+1 through the DONE cycle inclusive.
- start while busy (SUB, FIX or DONE) is ignored, with no queuing. start=1 held through DONE is accepted on the first IDLE edge.
- result and wrapped hold their values from DONE until the next operation's DONE. They are not cleared on accept.
- Input changes on a, b, m after acceptance have no effect.
- Precondition violation (a>=m or b>=m): output is the defined 2-pass arithmetic above, with no error flag.
- Arithmetic is modulo 2^WIDTH throughout. The carry-in at the SUB start implements two's-complement negation of b.

Test Plan:
- WIDTH=16, a=0x0005, b=0x0003, m=0x000B, start at edge T -> done only in cycle T+5; result=0x0002; wrapped=0; busy high T+1..T+5.
- a=0x0003, b=0x0005, m=0x000B -> done in cycle T+9; result=0x0009; wrapped=1.
- a=0x1234, b=0x1234, m=0xFFF1 -> result=0x0000, wrapped=0, done at T+5. Also a=0x0000, b=0xFFF0, m=0xFFF1 -> result=0x0001, wrapped=1, done at T+9 (carry ripples through all nibbles).
- Pulse start again at T+3 while busy, with different operands -> ignored; first result (0x0002) returned at T+5. Hold start high continuously -> back-to-back operations, with accept edges 6 cycles apart for no-borrow cases.
- Assert rst asynchronously mid-FIX (cycle T+7 of the borrow case) -> busy, done, wrapped, result go to 0 immediately with no done pulse. A new start after rst deasserts completes correctly.
- Change a, b, m on the cycle after acceptance -> result matches the latched values. Sweep WIDTH=4 (N=1) exhaustively over a, b < m for all m in 1..15 against a reference model.
